// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: 4-way round-robin arbiter that feeds one shared UART transmitter.
// Define UART_ARB_ERR_RETRY_EN so that each failed transfer is retried once before an error is reported.
module uart_tx_arbiter #(
  parameter int TIMEOUT_CYCLES = 20000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  req_valid_i,
  input  logic [31:0] req_data_i,
  output logic [3:0]  req_ready_o,
  output logic        uart_tx_start_o,
  output logic [7:0]  uart_tx_data_o,
  input  logic        uart_tx_done_i,
  input  logic        uart_tx_err_i,
  output logic        busy_o,
  output logic [1:0]  grant_id_o,
  output logic        done_pulse_o,
  output logic        err_pulse_o,
  output logic        timeout_pulse_o
);
  typedef enum logic [1:0] {IDLE, GRANT, START, WAIT} state_e;
  localparam logic [15:0] LAST_CNT = 16'(TIMEOUT_CYCLES - 1);
  state_e      state_q, state_d;
  logic [1:0]  grant_q, grant_d, last_q, last_d, pick, idx;
  logic [7:0]  data_q, data_d;
  logic [15:0] cnt_q, cnt_d;
  logic        done_q, done_d, err_q, err_d, to_q, to_d;
  logic        found, tmo, fail;
`ifdef UART_ARB_ERR_RETRY_EN
  logic        retry_q, retry_d;
`endif
  // Search starts one past the previous winner so every requester gets a turn.
  always_comb begin
    pick = last_q;
    found = 1'b0;
    idx = last_q;
    for (int k = 1; k <= 4; k++) begin
      idx = last_q + 2'(k);
      if (!found && req_valid_i[idx]) begin
        pick = idx;
        found = 1'b1;
      end
    end
  end
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    to_d    = 1'b0;
    tmo     = cnt_q == LAST_CNT;
    fail    = uart_tx_done_i ? uart_tx_err_i : tmo;
`ifdef UART_ARB_ERR_RETRY_EN
    retry_d = retry_q;
`endif
    case (state_q)
      IDLE: if (|req_valid_i) begin
        grant_d = pick;
        state_d = GRANT;
      end
      GRANT: begin
        data_d  = req_data_i[8*grant_q +: 8];
        state_d = START;
`ifdef UART_ARB_ERR_RETRY_EN
        retry_d = 1'b0;
`endif
      end
      START: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q + 16'd1;
        // A done arriving in the final timeout cycle wins over the timeout.
        if (uart_tx_done_i || tmo) begin
          last_d  = grant_q;
          state_d = IDLE;
`ifdef UART_ARB_ERR_RETRY_EN
          if (fail && !retry_q) begin
            retry_d = 1'b1;
            state_d = START;
          end else begin
            done_d = !fail;
            err_d  = fail;
            to_d   = fail && !uart_tx_done_i;
          end
`else
          done_d = !fail;
          err_d  = fail;
          to_d   = !uart_tx_done_i;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= 2'd0;
      last_q  <= 2'd3;
      data_q  <= 8'd0;
      cnt_q   <= 16'd0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
      to_q    <= to_d;
    end
  end
`ifdef UART_ARB_ERR_RETRY_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) retry_q <= 1'b0;
    else retry_q <= retry_d;
  end
`endif
  assign req_ready_o     = (state_q == GRANT) ? (4'b0001 << grant_q) : 4'b0000;
  assign uart_tx_start_o = state_q == START;
  assign busy_o          = state_q != IDLE;
  assign uart_tx_data_o  = data_q;
  assign grant_id_o      = grant_q;
  assign done_pulse_o    = done_q;
  assign err_pulse_o     = err_q;
  assign timeout_pulse_o = to_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: scoreboard bench for uart_tx_arbiter with a simple UART model.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;
  logic        clk = 1'b0, rst = 1'b1;
  logic [3:0]  req_valid_i = 4'b0;
  logic [31:0] req_data_i = 32'b0;
  logic        uart_tx_done_i = 1'b0, uart_tx_err_i = 1'b0;
  logic [3:0]  req_ready_o;
  logic        uart_tx_start_o, busy_o, done_pulse_o, err_pulse_o, timeout_pulse_o;
  logic [7:0]  uart_tx_data_o;
  logic [1:0]  grant_id_o;
  int          n_cmp = 0, n_bad = 0, cyc = 0, start_cyc = 0, n_start = 0, uart_lat = 5;
  bit          uart_hang = 1'b0, fail_now;
  bit          err_plan[$];
  logic [9:0]  exp_start[$];
  logic [2:0]  exp_end[$];
  logic [9:0]  e;

  uart_tx_arbiter #(.TIMEOUT_CYCLES(100)) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid_i), .req_data_i(req_data_i), .req_ready_o(req_ready_o),
    .uart_tx_start_o(uart_tx_start_o), .uart_tx_data_o(uart_tx_data_o),
    .uart_tx_done_i(uart_tx_done_i), .uart_tx_err_i(uart_tx_err_i),
    .busy_o(busy_o), .grant_id_o(grant_id_o), .done_pulse_o(done_pulse_o),
    .err_pulse_o(err_pulse_o), .timeout_pulse_o(timeout_pulse_o)
  );

  always #5 clk = ~clk;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    if (uart_tx_start_o) begin
      n_start++;
      start_cyc = cyc;
      if (exp_start.size() == 0) check("start_unexpected", exp_start.size(), 1);
      else begin
        e = exp_start.pop_front();
        check("start_id", grant_id_o, e[9:8]);
        check("start_data", uart_tx_data_o, e[7:0]);
      end
    end
    if (done_pulse_o || err_pulse_o || timeout_pulse_o) begin
      if (exp_end.size() == 0) check("pulse_unexpected", exp_end.size(), 1);
      else check("end_code", {done_pulse_o, err_pulse_o, timeout_pulse_o}, exp_end.pop_front());
      if (timeout_pulse_o) check("timeout_latency", cyc - start_cyc, 101);
    end
  end

  initial forever begin
    @(negedge clk);
    if (uart_tx_start_o && !uart_hang) begin
      fail_now = err_plan.size() != 0 ? err_plan.pop_front() : 1'b0;
      repeat (uart_lat) @(posedge clk);
      #1 uart_tx_done_i = 1'b1;
      uart_tx_err_i = fail_now;
      @(posedge clk);
      #1 uart_tx_done_i = 1'b0;
      uart_tx_err_i = 1'b0;
    end
  end

  task automatic wait_start(int base);
    for (int i = 0; i < 400 && n_start <= base; i++) @(posedge clk);
    #1 req_valid_i = 4'b0;
  endtask

  task automatic wait_drain(string tag, int budget);
    for (int i = 0; i < budget && (exp_start.size() != 0 || exp_end.size() != 0 || busy_o); i++)
      @(posedge clk);
    check(tag, exp_start.size() + exp_end.size() + 32'(busy_o), 0);
  endtask

  initial begin
    int base;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy_o, 0);
    check("rst_ready", req_ready_o, 0);
    check("rst_start", uart_tx_start_o, 0);
    check("rst_data", uart_tx_data_o, 0);
    check("rst_grant", grant_id_o, 0);
    check("rst_pulses", {done_pulse_o, err_pulse_o, timeout_pulse_o}, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    exp_start.push_back({2'd0, 8'hAF});
    exp_end.push_back(3'b100);
    req_data_i = 32'h000000AF;
    req_valid_i = 4'b0001;
    @(posedge clk);
    @(negedge clk);
    check("lat_ready", req_ready_o, 4'b0001);
    check("lat_busy", busy_o, 1);
    @(negedge clk);
    check("lat_start", uart_tx_start_o, 1);
    req_valid_i = 4'b0;
    wait_drain("t1_drain", 60);
    check("t1_idle", busy_o, 0);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    uart_lat = 50;
    base = n_start;
    for (int i = 0; i < 5; i++) begin
      exp_start.push_back({2'(i), 8'(8'h11 * ((i % 4) + 1))});
      exp_end.push_back(3'b100);
    end
    req_data_i = 32'h44332211;
    req_valid_i = 4'b1111;
    for (int i = 0; i < 2000 && n_start < base + 5; i++) @(posedge clk);
    #1 req_valid_i = 4'b0;
    wait_drain("rr_drain", 200);
    uart_hang = 1'b1;
    base = n_start;
    exp_start.push_back({2'd1, 8'h5A});
`ifdef UART_ARB_ERR_RETRY_EN
    exp_start.push_back({2'd1, 8'h5A});
`endif
    exp_end.push_back(3'b011);
    req_data_i = 32'h00005A00;
    req_valid_i = 4'b0010;
    wait_start(base);
    wait_drain("to_drain", 400);
    uart_hang = 1'b0;
    uart_lat = 3;
    base = n_start;
    err_plan.push_back(1'b1);
    exp_start.push_back({2'd3, 8'hC3});
`ifdef UART_ARB_ERR_RETRY_EN
    err_plan.push_back(1'b0);
    exp_start.push_back({2'd3, 8'hC3});
    exp_end.push_back(3'b100);
`else
    exp_end.push_back(3'b010);
`endif
    req_data_i = 32'hC3000000;
    req_valid_i = 4'b1000;
    wait_start(base);
    wait_drain("err_drain", 100);
    uart_lat = 100;
    base = n_start;
    exp_start.push_back({2'd0, 8'h7E});
    exp_end.push_back(3'b100);
    req_data_i = 32'h0000007E;
    req_valid_i = 4'b0001;
    wait_start(base);
    wait_drain("edge_drain", 300);
    uart_hang = 1'b1;
    base = n_start;
    exp_start.push_back({2'd2, 8'h9C});
    req_data_i = 32'h009C0000;
    req_valid_i = 4'b0100;
    wait_start(base);
    repeat (10) @(posedge clk);
    #3 rst = 1'b1;
    #1 check("arst_outputs", {busy_o, uart_tx_start_o, req_ready_o, uart_tx_data_o, grant_id_o,
                               done_pulse_o, err_pulse_o, timeout_pulse_o}, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    uart_hang = 1'b0;
    uart_lat = 4;
    base = n_start;
    exp_start.push_back({2'd0, 8'h31});
    exp_end.push_back(3'b100);
    req_data_i = 32'h009C0031;
    req_valid_i = 4'b0101;
    wait_start(base);
    wait_drain("post_rst_drain", 60);
    repeat (5) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish", $time);
    $fatal(1);
  end
endmodule
